// File: rtl/lsu_pkg.sv
// Shared types, defaults and decode helpers for the load/store bus controller.
package lsu_pkg;

  localparam int unsigned LSU_TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Unlisted funct3 codes behave as a full word access.
  function automatic mem_op_e lsu_decode_op(input logic [2:0] funct3);
    mem_op_e op;
    case (funct3)
      3'b000:  op = MEM_B;
      3'b001:  op = MEM_H;
      3'b100:  op = MEM_BU;
      3'b101:  op = MEM_HU;
      default: op = MEM_W;
    endcase
    return op;
  endfunction

  function automatic logic lsu_misaligned(input mem_op_e op, input logic [1:0] alo);
    logic mis;
    case (op)
      MEM_H, MEM_HU: mis = alo[0];
      MEM_W:         mis = |alo;
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a 32-bit bus read word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    // Halfwords use addr[1] only; an odd half address selects the containing half.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_i)
      MEM_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  data_o = {24'h000000, byte_sel};
      MEM_H:   data_o = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  data_o = {16'h0000, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: one outstanding access, stalls the pipeline until done.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses without a bus cycle.
//
// state   | meaning
// IDLE    | waiting for a load/store request
// REQ     | bus request held, waiting for ack or watchdog expiry
// DONE    | one-cycle completion: pipeline released, result/error reported
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [2:0]  mem_op_i,
  input  logic        mem_wren_i,
  input  logic        is_load_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  mem_op_e     op_q, op_d;
  logic [1:0]  alo_q, alo_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic        req;
  mem_op_e     op_dec;
  logic        mis_trap;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] align_data;

  assign req    = mem_wren_i | is_load_i;
  assign op_dec = lsu_decode_op(mem_op_i);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_trap = lsu_misaligned(op_dec, addr_i[1:0]);
`else
  assign mis_trap = 1'b0;
`endif

  always_comb begin
    case (op_dec)
      MEM_B, MEM_BU: begin
        st_be    = 4'b0001 << addr_i[1:0];
        st_wdata = {4{wdata_i[7:0]}};
      end
      MEM_H, MEM_HU: begin
        st_be    = 4'b0011 << {addr_i[1], 1'b0};
        st_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_i;
      end
    endcase
  end

  lsu_load_align u_align (
    .op_i      (op_q),
    .addr_lo_i (alo_q),
    .rdata_i   (bus_rdata_i),
    .data_o    (align_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    alo_d       = alo_q;
    we_d        = we_q;
    err_d       = err_q;
    mis_d       = mis_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    ld_data_d   = ld_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d  = op_dec;
          alo_d = addr_i[1:0];
          we_d  = mem_wren_i;
          err_d = 1'b0;
          mis_d = mis_trap;
          cnt_d = 8'd0;
          if (mis_trap) begin
            state_d = ST_DONE;
            if (!mem_wren_i) ld_data_d = 32'h0;
          end else begin
            state_d     = ST_REQ;
            bus_addr_d  = {addr_i[31:2], 2'b00};
            bus_wdata_d = mem_wren_i ? st_wdata : 32'h0;
            bus_be_d    = mem_wren_i ? st_be : 4'b1111;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // An ack on the final watchdog cycle still wins over the timeout.
        if (bus_ack_i) begin
          state_d = ST_DONE;
          if (!we_q) ld_data_d = align_data;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (!we_q) ld_data_d = 32'h0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      op_q        <= MEM_W;
      alo_q       <= 2'b00;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'b0000;
      ld_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      alo_q       <= alo_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      ld_data_q   <= ld_data_d;
    end
  end

  // Gated by reset so a request held during reset cannot leak a stall.
  assign stall_o     = reset_ni & (((state_q == ST_IDLE) & req) | (state_q == ST_REQ));
  assign bus_req_o   = (state_q == ST_REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;
  assign ld_data_o   = ld_data_q;
  assign ld_valid_o  = (state_q == ST_DONE) & ~we_q & ~err_q & ~mis_q;
  assign bus_err_o   = (state_q == ST_DONE) & err_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o  = (state_q == ST_DONE) & mis_q;
`else
  assign misalign_o  = 1'b0;
`endif

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 16, bus-ack watchdog limit in cycles (range 2..255).
REQ-002 clk_i  in  1  single clock, rising edge.
REQ-003 reset_ni  in  1  asynchronous active-low reset.
REQ-004 mem_op_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
REQ-005 mem_wren_i / is_load_i  in  1 each  store / load request from the MEM pipeline register.
REQ-006 addr_i  in  32  byte address (ALU result); wdata_i  in  32  store data (rs2).
REQ-007 stall_o  out  1  high = hold pipeline enables low.
REQ-008 ld_data_o  out  32  aligned, extended load result; ld_valid_o  out  1  load result valid.
REQ-009 bus_err_o / misalign_o  out  1 each  one-cycle error pulses.
REQ-010 bus_req_o, bus_we_o  out  1; bus_addr_o  out  32  word-aligned; bus_wdata_o  out  32; bus_be_o  out  4.
REQ-011 bus_ack_i  in  1; bus_rdata_i  in  32.

Function
REQ-012 Request = mem_wren_i | is_load_i; if both are high, the access SHALL be a store.
REQ-013 FSM states: IDLE, REQ, DONE.
REQ-014 IDLE + request: stall_o high combinationally in the same cycle; bus outputs registered; next state REQ.
REQ-015 REQ: bus_req_o high, all bus outputs stable, stall_o high until bus_ack_i is sampled high.
REQ-016 Ack in REQ: register bus_rdata_i; next state DONE; bus_req_o low from the next cycle.
REQ-017 DONE lasts one cycle: stall_o low; ld_valid_o high for loads only; next state IDLE. DONE ignores the request inputs.
REQ-018 Minimum latency: request in cycle 0, bus_req_o in cycle 1, zero-wait ack in cycle 1, DONE in cycle 2.
REQ-019 ld_data_o SHALL hold its last value until the next load completes.
REQ-020 Loads: select byte/half by addr_i[1:0]; B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-021 Stores: bus_be_o is 0001<<a (B), 0011<<a (H, a even), or 1111 (W); wdata byte/half is replicated across lanes.
REQ-022 Watchdog: 8-bit counter cleared on REQ entry, incremented in REQ; at TIMEOUT without ack, drop bus_req_o, go to DONE, pulse bus_err_o, ld_data_o=0.
REQ-023 An ack in the same cycle the counter reaches TIMEOUT SHALL complete normally with no error.

Reset
REQ-024 reset_ni low SHALL immediately force IDLE, counter=0, and every output to 0, including ld_data_o.
REQ-025 Reset during REQ drops bus_req_o asynchronously; the aborted access is not retried.

Configuration
REQ-026 Macro LSU_MISALIGN_TRAP_EN defined: misaligned H (addr[0]=1) or W (addr[1:0]!=0) issues no bus cycle; IDLE->DONE with stall for one cycle; misalign_o pulses in DONE; ld_data_o=0.
REQ-027 Macro undefined: misalign_o tied 0; misaligned low address bits ignored (H uses addr[1], W uses lane 0).

Structure
REQ-028 Package lsu_pkg SHALL hold the mem_op enum, the FSM state enum, and the TIMEOUT default.
REQ-029 Combinational sub-module lsu_load_align SHALL perform the lane select and extension.

Verification
REQ-030 LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> stall_o high 4 cycles; ld_data_o=0xDEADBEEF; ld_valid_o pulses once.
REQ-031 LB addr 0x103, rdata 0x80FF_FF7F -> ld_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr 0x102, wdata 0x0000ABCD -> bus_be_o=1100, bus_wdata_o=0xABCDABCD, bus_addr_o=0x100, bus_we_o=1.
REQ-033 LW with no ack, TIMEOUT=16 -> bus_req_o high 16 cycles, bus_err_o pulses, stall_o released; ack exactly at cycle 16 -> no error.
REQ-034 With LSU_MISALIGN_TRAP_EN, LW addr 0x102 -> no bus_req_o, misalign_o pulse; without the macro -> bus_addr_o=0x100.
REQ-035 reset_ni low mid-REQ -> bus_req_o and stall_o drop at once; after release, IDLE accepts a new LW normally.
